alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NREQ requesters, e.g. the execute stage and a multi-cycle address/branch helper.
- Each requester issues one operation over a valid/ready handshake. The arbiter picks one round-robin, registers the operands, drives the ALU for one cycle and captures the result and flags.
- The result is held on a shared response bus until the owning requester acknowledges it.
- Sits between the requesters and the alu_if instance.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/rr_picker.sv | 30 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types plus the ALU arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick; first valid requester at or above rr_ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [GW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [GW-1:0]   gnt_idx
);

    logic          found;
    logic [GW-1:0] idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = GW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NREQ requesters, round-robin,
// one operation in flight; the result is held until its owner acknowledges it.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  aluop_t          req_aluop [NREQ],
    input  word_t           req_portA [NREQ],
    input  word_t           req_portB [NREQ],
    output aluop_t          alu_aluop,
    output word_t           alu_portA,
    output word_t           alu_portB,
    input  word_t           alu_outport,
    input  logic            alu_zero,
    input  logic            alu_negative,
    input  logic            alu_overflow,
    output logic [NREQ-1:0] resp_valid,
    output word_t           resp_data,
    output logic            resp_zero,
    output logic            resp_negative,
    output logic            resp_overflow,
    input  logic [NREQ-1:0] resp_ack
);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    aluop_t        op_q, op_d;
    word_t         a_q, a_d;
    word_t         b_q, b_d;
    word_t         rdata_q, rdata_d;
    logic          rz_q, rz_d;
    logic          rn_q, rn_d;
    logic          ro_q, ro_d;

    logic [NREQ-1:0] pick_oh;
    logic [GW-1:0]   pick_idx;

    rr_picker #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt_oh    (pick_oh),
        .gnt_idx   (pick_idx)
    );

    // Ready is held low while reset is asserted even though the state register sits in IDLE.
    assign req_ready     = (state_q == IDLE && nRST) ? pick_oh : '0;
    assign resp_valid    = (state_q == RESP) ? (NREQ'(1) << grant_q) : '0;
    assign alu_aluop     = op_q;
    assign alu_portA     = a_q;
    assign alu_portB     = b_q;
    assign resp_data     = rdata_q;
    assign resp_zero     = rz_q;
    assign resp_negative = rn_q;
    assign resp_overflow = ro_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rdata_d  = rdata_q;
        rz_d     = rz_q;
        rn_d     = rn_q;
        ro_d     = ro_q;
        case (state_q)
            IDLE: if (|pick_oh) begin
                op_d    = req_aluop[pick_idx];
                a_d     = req_portA[pick_idx];
                b_d     = req_portB[pick_idx];
                grant_d = pick_idx;
                state_d = EXEC;
            end
            EXEC: begin
                rdata_d = alu_outport;
                rz_d    = alu_zero;
                rn_d    = alu_negative;
                ro_d    = alu_overflow;
                state_d = RESP;
            end
            RESP: if (resp_ack[grant_q]) begin
                rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= ALU_SLL;
            a_q      <= '0;
            b_q      <= '0;
            rdata_q  <= '0;
            rz_q     <= 1'b0;
            rn_q     <= 1'b0;
            ro_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rdata_q  <= rdata_d;
            rz_q     <= rz_d;
            rn_q     <= rn_d;
            ro_q     <= ro_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ = 2;

    typedef struct packed {
        word_t d;
        logic  z;
        logic  n;
        logic  o;
    } res_t;

    typedef struct {
        int   id;
        res_t r;
    } exp_t;

    logic            CLK, nRST;
    logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ack;
    aluop_t          req_aluop [NREQ];
    word_t           req_portA [NREQ];
    word_t           req_portB [NREQ];
    aluop_t          alu_aluop;
    word_t           alu_portA, alu_portB, alu_outport, resp_data;
    logic            alu_zero, alu_negative, alu_overflow;
    logic            resp_zero, resp_negative, resp_overflow;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic   pend_v [NREQ];
    aluop_t pend_op [NREQ];
    word_t  pend_a [NREQ];
    word_t  pend_b [NREQ];
    int     mptr = 0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_portA(req_portA), .req_portB(req_portB),
        .alu_aluop(alu_aluop), .alu_portA(alu_portA), .alu_portB(alu_portB),
        .alu_outport(alu_outport), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_zero(resp_zero),
        .resp_negative(resp_negative), .resp_overflow(resp_overflow),
        .resp_ack(resp_ack)
    );

    function automatic res_t alu_model(input aluop_t op, input word_t a, input word_t b);
        res_t r;
        r = '0;
        case (op)
            ALU_SLL:  r.d = a << b[4:0];
            ALU_SRL:  r.d = a >> b[4:0];
            ALU_ADD:  begin r.d = a + b; r.o = (a[31] == b[31]) && (r.d[31] != a[31]); end
            ALU_SUB:  begin r.d = a - b; r.o = (a[31] != b[31]) && (r.d[31] != a[31]); end
            ALU_AND:  r.d = a & b;
            ALU_OR:   r.d = a | b;
            ALU_XOR:  r.d = a ^ b;
            ALU_NOR:  r.d = ~(a | b);
            ALU_SLT:  r.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: r.d = (a < b) ? 32'd1 : 32'd0;
            default:  r.d = '0;
        endcase
        r.z = (r.d == 0);
        r.n = r.d[31];
        return r;
    endfunction

    // Stand-in for the shared alu_if instance.
    always_comb begin
        res_t r;
        r = alu_model(alu_aluop, alu_portA, alu_portB);
        alu_outport  = r.d;
        alu_zero     = r.z;
        alu_negative = r.n;
        alu_overflow = r.o;
    end

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the oldest expectation.
    always @(negedge CLK) begin
        if (nRST && resp_valid != 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'(0));
            end else begin
                chk("resp_owner", 64'(resp_valid), 64'(1 << sb[0].id));
                chk("resp_data", 64'(resp_data), 64'(sb[0].r.d));
                chk("resp_flags", 64'({resp_zero, resp_negative, resp_overflow}),
                    64'({sb[0].r.z, sb[0].r.n, sb[0].r.o}));
                chk("ready_while_resp", 64'(req_ready), 64'(0));
                if ((resp_valid & resp_ack) != 0) void'(sb.pop_front());
            end
        end
    end

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend_v[i];
            req_aluop[i] = pend_op[i];
            req_portA[i] = pend_a[i];
            req_portB[i] = pend_b[i];
        end
    endtask

    task automatic set_req(input int id, input aluop_t op, input word_t a, input word_t b);
        pend_v[id]  = 1'b1;
        pend_op[id] = op;
        pend_a[id]  = a;
        pend_b[id]  = b;
    endtask

    function automatic int model_pick();
        for (int k = 0; k < NREQ; k++)
            if (pend_v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        return -1;
    endfunction

    // One full transaction; entered and left just after a rising edge with the DUT idle.
    task automatic do_txn(input int dly, input bit stray);
        int   w;
        exp_t e;
        drive_reqs();
        w = model_pick();
        @(negedge CLK);
        chk("ready_winner", 64'(req_ready), 64'(1 << w));
        e.id = w;
        e.r  = alu_model(pend_op[w], pend_a[w], pend_b[w]);
        sb.push_back(e);
        @(posedge CLK); #1;
        pend_v[w] = 1'b0;
        drive_reqs();
        @(negedge CLK);
        chk("exec_quiet", 64'({req_ready, resp_valid}), 64'(0));
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("latency", 64'(resp_valid), 64'(1 << w));
        @(posedge CLK); #1;
        repeat (dly) begin
            resp_ack = stray ? ~(NREQ'(1) << w) : '0;
            @(posedge CLK); #1;
        end
        resp_ack = NREQ'(1) << w;
        @(posedge CLK); #1;
        resp_ack = '0;
        mptr = (w + 1) % NREQ;
    endtask

    function automatic word_t rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        nRST = 0;
        resp_ack = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, ALU_SLL, '0, '0);
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        drive_reqs();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_resp", 64'({resp_valid, resp_zero, resp_negative, resp_overflow}), 64'(0));
        chk("rst_data", 64'(resp_data), 64'(0));
        chk("rst_alu", 64'({alu_aluop, alu_portA, alu_portB}), 64'(0));
        nRST = 1;

        // Contention from reset: 0 then 1, and 0 again once the pointer wraps.
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        set_req(1, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        do_txn(0, 0);
        do_txn(1, 0);
        set_req(0, ALU_OR, 32'h1, 32'h2);
        set_req(1, ALU_AND, 32'hFF, 32'h0F);
        do_txn(0, 0);
        do_txn(0, 0);

        set_req(0, ALU_ADD, 32'd5, 32'd7);
        do_txn(0, 0);
        set_req(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        do_txn(0, 0);
        set_req(1, ALU_SUB, 32'h1234, 32'h1234);
        do_txn(2, 0);

        // Backpressure with a stray ack on the other bit.
        set_req(0, ALU_SRL, 32'h8000_0000, 32'd4);
        do_txn(10, 1);

        set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        set_req(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        do_txn(1, 1);
        do_txn(1, 1);

        // Reset during EXEC; winner before reset is requester 1 (pointer at 1).
        set_req(0, ALU_NOR, 32'h1, 32'h2);
        do_txn(0, 0);
        set_req(0, ALU_ADD, 32'h11, 32'h22);
        set_req(1, ALU_SUB, 32'h33, 32'h44);
        drive_reqs();
        @(negedge CLK);
        chk("prereset_winner", 64'(req_ready), 64'(2));
        @(posedge CLK); #2;
        nRST = 0;
        #1;
        chk("midrst_alu", 64'({alu_aluop, alu_portA, alu_portB}), 64'(0));
        chk("midrst_out", 64'({req_ready, resp_valid}), 64'(0));
        chk("midrst_flags", 64'({resp_data, resp_zero, resp_negative, resp_overflow}), 64'(0));
        sb.delete();
        mptr = 0;
        @(posedge CLK); #1;
        nRST = 1;
        do_txn(0, 0);
        do_txn(0, 0);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend_v[i] && $urandom_range(0, 1) == 1)
                    set_req(i, aluop_t'($urandom_range(0, 9)), rand_word(), rand_word());
            if (model_pick() < 0)
                set_req($urandom_range(0, NREQ - 1), aluop_t'($urandom_range(0, 9)), rand_word(), rand_word());
            do_txn($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        repeat (3) @(posedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
